led_blink_scheduler: RTL and testbench
======================================

Name: led_blink_scheduler

Overview:
- Controller for the board LED blinker datapath. It resolves the four rate-select switches into one blink period by fixed priority and runs the prescaler and period counters. It also debounces a pushbutton that steps through four display patterns and drives all 18 board LEDs.
- Sits between the board I/O (SW, KEY, LEDG, LEDR) and the LEDs, replacing ad-hoc per-switch compare logic.

Parameters:
- HALF_SEC_CYCLES, 25000000, CLOCK_50 cycles per 0.5 s base tick.
- DEBOUNCE_CYCLES, 1000000, cycles KEY_MODE must be stable before it is accepted (20 ms).
- CNT_W, 28, prescaler/debounce counter width; must hold max(HALF_SEC_CYCLES, DEBOUNCE_CYCLES).

Ports:
- CLOCK_50  in  1  system clock, 50 MHz, sole clock.
- RESET_N  in  1  reset, asynchronous, active-low.
- SW  in  4  rate request: SW[0]=0.5 s, SW[1]=1 s, SW[2]=2 s, SW[3]=3 s.
- KEY_MODE  in  1  pushbutton, active-low, asynchronous to CLOCK_50.
- LEDG  out  8  pattern bits V[7:0].
- LEDR  out  10  pattern bits V[17:8].
- STEP  out  1  one-cycle pulse per pattern step.
- MODE  out  2  current pattern mode: 0=ALT, 1=ALL, 2=CHASE, 3=FILL.

Behaviour:
- Reset (async assert, sync release): MODE=0, phase=0, pos=0, all counters=0, STEP=0, LEDG=8'h55, LEDR=10'h155. All outputs are registered.
- Rate arbitration:
  - Highest set SW index wins.
  - Period N in half-ticks: SW3→6, SW2→4, SW1→2, SW0→1.
  - SW=0000 → IDLE: counters held at 0, no STEP, LEDs hold last pattern.
- Prescaler: counts 0..HALF_SEC_CYCLES-1, then wraps and emits an internal half-tick.
- Period counter: counts half-ticks 0..N-1. On the half-tick where it equals N-1, it wraps to 0 and STEP=1 for exactly that cycle.
- Rate change: any cycle where the resolved N differs from the previous cycle's N clears both counters to 0. No STEP is issued that cycle. The first STEP follows exactly N*HALF_SEC_CYCLES cycles later; compare overshoot is impossible.
- KEY_MODE path:
  - 2-flop synchronizer, then debounce counter.
  - The debounced level changes only after the synced input differs from it for DEBOUNCE_CYCLES consecutive cycles. Any bounce restarts the count.
  - A falling edge of the debounced level is a press; MODE advances 0→1→2→3→0.
  - Holding the button gives exactly one advance.
- Pattern state advances only on STEP:
  - phase toggles.
  - pos increments 0..17 and wraps 17→0.
- Pattern vector V[17:0] is registered one cycle after a STEP or mode change:
  - ALT: V[i] = ~phase for even i, phase for odd i.
  - ALL: V = {18{phase}}.
  - CHASE: one-hot at bit pos.
  - FILL: bits 0..pos set, all others clear.
- Simultaneous press and STEP: the mode change wins. phase and pos clear to 0 and that STEP's advance is dropped. The STEP pulse still appears on the port. Rate counters are unaffected by mode changes.
- Reset mid-operation: immediate return to reset values, including the debounce state; a button held through reset release does not generate a press.

Test Plan (HALF_SEC_CYCLES=10, DEBOUNCE_CYCLES=4):
- Reset check: assert RESET_N=0 with SW=0001 → LEDG=8'h55, LEDR=10'h155, MODE=0, STEP=0, for as long as reset is held.
- Rate timing:
  - SW=0001 → STEP every 10 cycles; LEDG alternates 8'hAA/8'h55.
  - SW=1001 → SW3 wins, STEP every 60 cycles.
  - SW=0000 → no STEP for 200 cycles, LEDs frozen.
- Rate change mid-count: SW 0001→0100 at prescaler count 7 → no STEP for 39 cycles, first STEP exactly 40 cycles after the change.
- Debounce:
  - KEY_MODE low 2 cycles, then high → MODE stays 0.
  - KEY_MODE low 20 cycles → MODE=1 exactly once; LEDG then toggles 8'h00/8'hFF on each STEP.
- CHASE/FILL wrap:
  - In CHASE, 17 STEPs → LEDR=10'h200; next STEP → LEDG=8'h01, LEDR=0.
  - In FILL, 17 STEPs → all LEDs on; next STEP → LEDG=8'h01.
- Collision and async reset:
  - A press accepted on the same cycle as STEP → pos=0, phase=0, no advance.
  - Pulling RESET_N low between clock edges → outputs reach reset values before the next edge.

Source files
------------

// File: rtl/led_blink_scheduler_if.sv
// Board-side bundle for the LED blink scheduler: rate switches, mode key, LED
// banks and the step/mode status outputs.
interface led_blink_scheduler_if;
  logic [3:0] SW;
  logic       KEY_MODE;
  logic [7:0] LEDG;
  logic [9:0] LEDR;
  logic       STEP;
  logic [1:0] MODE;

  modport master (
    output SW,
    output KEY_MODE,
    input  LEDG,
    input  LEDR,
    input  STEP,
    input  MODE
  );

  modport slave (
    input  SW,
    input  KEY_MODE,
    output LEDG,
    output LEDR,
    output STEP,
    output MODE
  );
endinterface

// File: rtl/led_blink_scheduler.sv
// Priority-resolved blink rate, half-second prescaler/period counters, debounced
// mode key and the four-pattern LED vector for the 18 board LEDs.
module led_blink_scheduler #(
  parameter int HALF_SEC_CYCLES = 25000000,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int CNT_W           = 28
) (
  input  logic                  CLOCK_50,
  input  logic                  RESET_N,
  led_blink_scheduler_if.slave  bus
);

  localparam logic [CNT_W-1:0] PRESC_LAST = CNT_W'(HALF_SEC_CYCLES - 1);
  localparam logic [CNT_W-1:0] DEB_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    MODE_ALT   = 2'd0,
    MODE_ALL   = 2'd1,
    MODE_CHASE = 2'd2,
    MODE_FILL  = 2'd3
  } mode_t;

  logic [2:0]       period_n;
  logic [2:0]       period_prev;
  logic [CNT_W-1:0] presc;
  logic [2:0]       per;
  logic             idle;
  logic             rate_chg;
  logic             half_tick;
  logic             step_fire;
  logic             step_q;

  logic             key_p0;
  logic             key_p1;
  logic             vld_p0;
  logic             vld_p1;
  logic             db_vld;
  logic             key_db;
  logic [CNT_W-1:0] db_cnt;
  logic             db_commit;
  logic             press;

  mode_t            mode_q;
  mode_t            mode_d;
  logic             phase_q;
  logic             phase_d;
  logic [4:0]       pos_q;
  logic [4:0]       pos_d;
  logic [17:0]      vec_d;
  logic [17:0]      vec_q;

  // Rate arbitration: highest switch index wins, period in half-ticks.
  always_comb begin
    period_n = 3'd0;
    if (bus.SW[3])      period_n = 3'd6;
    else if (bus.SW[2]) period_n = 3'd4;
    else if (bus.SW[1]) period_n = 3'd2;
    else if (bus.SW[0]) period_n = 3'd1;
  end

  assign idle      = (period_n == 3'd0);
  assign rate_chg  = (period_n != period_prev);
  assign half_tick = (presc == PRESC_LAST);
  assign step_fire = !idle && !rate_chg && half_tick && (per == period_n - 3'd1);

  // Counters restart from zero on any rate change so the first step after it
  // lands exactly one full period later.
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      presc       <= '0;
      per         <= '0;
      period_prev <= '0;
      step_q      <= 1'b0;
    end else begin
      period_prev <= period_n;
      step_q      <= step_fire;
      if (idle || rate_chg) begin
        presc <= '0;
        per   <= '0;
      end else if (half_tick) begin
        presc <= '0;
        per   <= (per == period_n - 3'd1) ? 3'd0 : per + 3'd1;
      end else begin
        presc <= presc + 1'b1;
      end
    end
  end

  // Key synchronizer stages p0/p1; the valid bits let the debouncer adopt the
  // first real sample silently, so a key held through reset never counts.
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      key_p0 <= 1'b1;
      key_p1 <= 1'b1;
      vld_p0 <= 1'b0;
      vld_p1 <= 1'b0;
      db_vld <= 1'b0;
      key_db <= 1'b1;
      db_cnt <= '0;
    end else begin
      key_p0 <= bus.KEY_MODE;
      key_p1 <= key_p0;
      vld_p0 <= 1'b1;
      vld_p1 <= vld_p0;
      if (!db_vld) begin
        if (vld_p1) begin
          key_db <= key_p1;
          db_vld <= 1'b1;
        end
        db_cnt <= '0;
      end else if (key_p1 == key_db) begin
        db_cnt <= '0;
      end else if (db_commit) begin
        key_db <= key_p1;
        db_cnt <= '0;
      end else begin
        db_cnt <= db_cnt + 1'b1;
      end
    end
  end

  assign db_commit = db_vld && (key_p1 != key_db) && (db_cnt == DEB_LAST);
  assign press     = db_commit && key_db;

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      mode_q  <= MODE_ALT;
      phase_q <= 1'b0;
      pos_q   <= '0;
    end else begin
      mode_q  <= mode_d;
      phase_q <= phase_d;
      pos_q   <= pos_d;
    end
  end

  // A press on a step cycle wins and discards that step's advance.
  always_comb begin
    mode_d  = mode_q;
    phase_d = phase_q;
    pos_d   = pos_q;
    if (press) begin
      case (mode_q)
        MODE_ALT:   mode_d = MODE_ALL;
        MODE_ALL:   mode_d = MODE_CHASE;
        MODE_CHASE: mode_d = MODE_FILL;
        default:    mode_d = MODE_ALT;
      endcase
      phase_d = 1'b0;
      pos_d   = '0;
    end else if (step_fire) begin
      phase_d = ~phase_q;
      pos_d   = (pos_q == 5'd17) ? 5'd0 : pos_q + 5'd1;
    end
  end

  always_comb begin
    vec_d = '0;
    case (mode_q)
      MODE_ALT: begin
        for (int i = 0; i < 18; i++) vec_d[i] = (i % 2 == 0) ? ~phase_q : phase_q;
      end
      MODE_ALL:   vec_d = {18{phase_q}};
      MODE_CHASE: vec_d = 18'd1 << pos_q;
      default: begin
        for (int i = 0; i < 18; i++) vec_d[i] = (5'(i) <= pos_q);
      end
    endcase
  end

  // Pattern register: follows the mode/phase/pos state one cycle later.
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) vec_q <= 18'h15555;
    else          vec_q <= vec_d;
  end

  assign bus.LEDG = vec_q[7:0];
  assign bus.LEDR = vec_q[17:8];
  assign bus.STEP = step_q;
  assign bus.MODE = mode_q;

endmodule

// File: tb/tb_led_blink_scheduler.sv
// Directed bench for led_blink_scheduler with shortened prescaler and debounce.
module tb_led_blink_scheduler;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad = 0;
  int   m_mode = 0;
  bit   m_phase = 1'b0;
  int   m_pos = 0;

  led_blink_scheduler_if bus();

  led_blink_scheduler #(
    .HALF_SEC_CYCLES(10),
    .DEBOUNCE_CYCLES(4),
    .CNT_W(28)
  ) dut (
    .CLOCK_50(clk),
    .RESET_N (rst_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] sw;
    int         period;
  } rate_vec_t;

  rate_vec_t rate_tab [8];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [17:0] exp_vec(input int m, input bit ph, input int p);
    logic [17:0] v;
    v = '0;
    case (m)
      0: for (int i = 0; i < 18; i++) v[i] = (i % 2 == 0) ? ~ph : ph;
      1: v = {18{ph}};
      2: v[p] = 1'b1;
      default: for (int i = 0; i < 18; i++) v[i] = (i <= p);
    endcase
    return v;
  endfunction

  task automatic check_leds(input string name);
    logic [17:0] v;
    v = exp_vec(m_mode, m_phase, m_pos);
    check({name, "_ledg"}, int'(bus.LEDG), int'(v[7:0]));
    check({name, "_ledr"}, int'(bus.LEDR), int'(v[17:8]));
    check({name, "_mode"}, int'(bus.MODE), m_mode);
  endtask

  task automatic model_step();
    m_phase = ~m_phase;
    m_pos   = (m_pos == 17) ? 0 : m_pos + 1;
  endtask

  task automatic model_press();
    m_mode  = (m_mode + 1) % 4;
    m_phase = 1'b0;
    m_pos   = 0;
  endtask

  task automatic wait_step(input int budget, output int cyc);
    int k;
    cyc = -1;
    k   = 0;
    while (cyc < 0 && k < budget) begin
      tick();
      k++;
      if (bus.STEP === 1'b1) cyc = k;
    end
  endtask

  task automatic step_and_check(input string name, input int exp_cyc);
    int c;
    wait_step(exp_cyc + 5, c);
    check({name, "_period"}, c, exp_cyc);
    if (c > 0) model_step();
    tick();
    check_leds(name);
  endtask

  task automatic press_key();
    bus.KEY_MODE = 1'b0;
    repeat (10) tick();
    bus.KEY_MODE = 1'b1;
    repeat (10) tick();
  endtask

  initial begin
    int c;
    int changes;
    logic [1:0] prev_mode;
    logic [7:0] snap_g;
    logic [9:0] snap_r;
    bit saw_step;
    bit leds_moved;

    rate_tab[0] = '{4'b0001, 10};
    rate_tab[1] = '{4'b0010, 20};
    rate_tab[2] = '{4'b0100, 40};
    rate_tab[3] = '{4'b1000, 60};
    rate_tab[4] = '{4'b1001, 60};
    rate_tab[5] = '{4'b0011, 20};
    rate_tab[6] = '{4'b0110, 40};
    rate_tab[7] = '{4'b1111, 60};

    bus.SW       = 4'b0001;
    bus.KEY_MODE = 1'b1;
    rst_n        = 1'b0;

    // Reset held with a rate selected
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rst_ledg", int'(bus.LEDG), 'h55);
      check("rst_ledr", int'(bus.LEDR), 'h155);
      check("rst_mode", int'(bus.MODE), 0);
      check("rst_step", int'(bus.STEP), 0);
    end
    rst_n = 1'b1;

    // Rate table: each entry entered from idle, two consecutive periods timed
    for (int i = 0; i < 8; i++) begin
      bus.SW = 4'b0000;
      tick();
      bus.SW = rate_tab[i].sw;
      tick();
      step_and_check($sformatf("rate%0d_first", i), rate_tab[i].period);
      step_and_check($sformatf("rate%0d_second", i), rate_tab[i].period - 1);
    end

    // Rate change at prescaler count 7
    bus.SW = 4'b0000;
    tick();
    bus.SW = 4'b0001;
    tick();
    wait_step(15, c);
    check("midcnt_setup", c, 10);
    if (c > 0) model_step();
    repeat (7) tick();
    bus.SW = 4'b0100;
    tick();
    step_and_check("midcnt_change", 40);

    // Idle freezes everything
    bus.SW = 4'b0000;
    tick();
    snap_g = bus.LEDG;
    snap_r = bus.LEDR;
    saw_step = 1'b0;
    leds_moved = 1'b0;
    for (int i = 0; i < 200; i++) begin
      tick();
      if (bus.STEP !== 1'b0) saw_step = 1'b1;
      if (bus.LEDG !== snap_g || bus.LEDR !== snap_r) leds_moved = 1'b1;
    end
    check("idle_step", int'(saw_step), 0);
    check("idle_leds", int'(leds_moved), 0);

    // Short glitch on the key
    bus.KEY_MODE = 1'b0;
    tick();
    tick();
    bus.KEY_MODE = 1'b1;
    repeat (12) tick();
    check("glitch_mode", int'(bus.MODE), 0);

    // Long press: exactly one advance
    changes = 0;
    prev_mode = bus.MODE;
    bus.KEY_MODE = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (i == 20) bus.KEY_MODE = 1'b1;
      tick();
      if (bus.MODE !== prev_mode) changes++;
      prev_mode = bus.MODE;
    end
    check("press_changes", changes, 1);
    model_press();
    check_leds("all_entry");

    bus.SW = 4'b0001;
    tick();
    step_and_check("all_s1", 10);
    step_and_check("all_s2", 9);
    step_and_check("all_s3", 9);

    // Press accepted on the same edge as a step
    wait_step(15, c);
    check("coll_align", c, 9);
    if (c > 0) model_step();
    repeat (4) tick();
    bus.KEY_MODE = 1'b0;
    repeat (6) tick();
    check("coll_step", int'(bus.STEP), 1);
    check("coll_mode", int'(bus.MODE), 2);
    model_press();
    bus.KEY_MODE = 1'b1;
    tick();
    check_leds("coll");
    check("coll_ledg_pos0", int'(bus.LEDG), 'h01);

    // CHASE wrap
    for (int i = 0; i < 17; i++) step_and_check($sformatf("chase%0d", i), 9);
    check("chase17_ledr", int'(bus.LEDR), 'h200);
    check("chase17_ledg", int'(bus.LEDG), 'h00);
    step_and_check("chase_wrap", 9);
    check("chase_wrap_ledg", int'(bus.LEDG), 'h01);
    check("chase_wrap_ledr", int'(bus.LEDR), 'h000);

    // FILL wrap
    bus.SW = 4'b0000;
    tick();
    press_key();
    model_press();
    check_leds("fill_entry");
    bus.SW = 4'b0001;
    tick();
    step_and_check("fill0", 10);
    for (int i = 1; i < 17; i++) step_and_check($sformatf("fill%0d", i), 9);
    check("fill17_ledg", int'(bus.LEDG), 'hFF);
    check("fill17_ledr", int'(bus.LEDR), 'h3FF);
    step_and_check("fill_wrap", 9);
    check("fill_wrap_ledg", int'(bus.LEDG), 'h01);

    // Wrap FILL -> ALT -> ALL
    bus.SW = 4'b0000;
    tick();
    press_key();
    model_press();
    check_leds("alt_again");
    press_key();
    model_press();
    check_leds("all_again");

    // Asynchronous reset between edges, key held through release
    @(posedge clk);
    #4;
    rst_n = 1'b0;
    bus.KEY_MODE = 1'b0;
    #1;
    check("arst_ledg", int'(bus.LEDG), 'h55);
    check("arst_ledr", int'(bus.LEDR), 'h155);
    check("arst_mode", int'(bus.MODE), 0);
    check("arst_step", int'(bus.STEP), 0);
    m_mode  = 0;
    m_phase = 1'b0;
    m_pos   = 0;
    tick();
    tick();
    rst_n = 1'b1;
    repeat (20) tick();
    check("held_key_mode", int'(bus.MODE), 0);
    bus.KEY_MODE = 1'b1;
    repeat (10) tick();
    check_leds("held_key_release");
    press_key();
    model_press();
    check_leds("post_reset_press");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
